// File: rtl/arrow_sequencer.sv
// Arrow game sequencer: picks an LFSR-driven arrow each round, judges button
// presses against it, and keeps saturating hit/miss counts over a fixed number of rounds.
module arrow_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned ROUNDS      = 16,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         btn,
    output logic [1:0]         direction,
    output logic               vga_on,
    output logic               active,
    output logic [SCORE_W-1:0] hit_count,
    output logic [SCORE_W-1:0] miss_count,
    output logic               game_over
);

    localparam int unsigned MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] BEAT_LOAD = TW'(BEAT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        HIT,
        MISS,
        GAP,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic [7:0]         round, round_n;
    logic [7:0]         lfsr, lfsr_n;
    logic [1:0]         dir, dir_n;
    logic [SCORE_W-1:0] hits, hits_n;
    logic [SCORE_W-1:0] misses, misses_n;

    logic [3:0] sync1, sync2, prev;
    logic [3:0] rise;
    logic [3:0] expect_btn;
    logic       good, bad, timer_zero;
    logic [7:0] lfsr_step, seed_step;
    logic [SCORE_W-1:0] hits_inc, misses_inc;

    // Buttons are asynchronous: two flops for metastability, a third for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise       = sync2 & ~prev;
    assign expect_btn = 4'b0001 << dir;
    assign good       = (rise == expect_btn);
    assign bad        = (rise != 4'b0000) && !good;
    assign timer_zero = (timer == '0);

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign seed_step = {LFSR_SEED[6:0],
                        LFSR_SEED[7] ^ LFSR_SEED[5] ^ LFSR_SEED[4] ^ LFSR_SEED[3]};

    assign hits_inc   = (&hits)   ? hits   : hits   + SCORE_W'(1);
    assign misses_inc = (&misses) ? misses : misses + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            round  <= '0;
            lfsr   <= LFSR_SEED;
            dir    <= '0;
            hits   <= '0;
            misses <= '0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            round  <= round_n;
            lfsr   <= lfsr_n;
            dir    <= dir_n;
            hits   <= hits_n;
            misses <= misses_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        round_n  = round;
        lfsr_n   = lfsr;
        dir_n    = dir;
        hits_n   = hits;
        misses_n = misses;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = SHOW;
                    hits_n   = '0;
                    misses_n = '0;
                    round_n  = 8'd1;
                    lfsr_n   = seed_step;
                    dir_n    = seed_step[1:0];
                    timer_n  = BEAT_LOAD;
                end
            end

            SHOW: begin
                // A press landing on the last beat cycle is judged and the round
                // still closes this cycle, so no timeout miss is added on top.
                if (good || bad) begin
                    if (good) hits_n   = hits_inc;
                    else      misses_n = misses_inc;
                    if (timer_zero) begin
                        state_n = GAP;
                        timer_n = GAP_LOAD;
                    end else begin
                        state_n = good ? HIT : MISS;
                        timer_n = timer - 1'b1;
                    end
                end else if (timer_zero) begin
                    misses_n = misses_inc;
                    state_n  = GAP;
                    timer_n  = GAP_LOAD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            HIT, MISS: begin
                if (timer_zero) begin
                    state_n = GAP;
                    timer_n = GAP_LOAD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            GAP: begin
                if (timer_zero) begin
                    if (round == LAST_ROUND) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHOW;
                        round_n = round + 8'd1;
                        lfsr_n  = lfsr_step;
                        dir_n   = lfsr_step[1:0];
                        timer_n = BEAT_LOAD;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign direction  = dir;
    assign vga_on     = (state == HIT);
    assign active     = (state == SHOW) || (state == HIT) || (state == MISS);
    assign game_over  = (state == DONE);
    assign hit_count  = hits;
    assign miss_count = misses;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Directed bench for arrow_sequencer with short beat/gap and three rounds.
module tb_arrow_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic [1:0] direction;
    logic       vga_on;
    logic       active;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic       game_over;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [1:0]  exp_dir [3];
    int unsigned vga_seen;

    arrow_sequencer #(
        .BEAT_CYCLES(8),
        .GAP_CYCLES (2),
        .ROUNDS     (3),
        .LFSR_SEED  (8'hA5),
        .SCORE_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .direction (direction),
        .vga_on    (vga_on),
        .active    (active),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_vga"}, 32'(vga_on), 0);
        check({tag, "_hit"}, 32'(hit_count), 0);
        check({tag, "_miss"}, 32'(miss_count), 0);
        check({tag, "_over"}, 32'(game_over), 0);
        check({tag, "_dir"}, 32'(direction), 0);
    endtask

    initial begin
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            l = lfsr_next(l);
            exp_dir[i] = l[1:0];
        end
        // Hand-derived: A5 -> 4A -> 95 -> 2A
        check("model_dir0", 32'(exp_dir[0]), 2);
        check("model_dir1", 32'(exp_dir[1]), 1);
        check("model_dir2", 32'(exp_dir[2]), 2);

        reset = 1'b1; start = 1'b0; btn = 4'b0;
        tick(2);
        check_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn = 4'(i);
            tick();
        end
        btn = 4'b0;
        tick(3);
        check_idle("idle");

        // Game A: correct press three cycles into SHOW, then timeouts.
        start = 1'b1; tick(); start = 1'b0;
        check("a_active", 32'(active), 1);
        check("a_dir0", 32'(direction), 32'(exp_dir[0]));
        tick(2);
        btn = 4'b0001 << exp_dir[0];
        tick(); check("a_vga_k", 32'(vga_on), 0);
        tick(); check("a_vga_k1", 32'(vga_on), 0);
        tick(); check("a_vga_k2", 32'(vga_on), 1);
        check("a_hit1", 32'(hit_count), 1);
        btn = 4'b0;
        tick(2); check("a_vga_end", 32'(vga_on), 1);
        tick();
        check("a_gap_vga", 32'(vga_on), 0);
        check("a_gap_active", 32'(active), 0);
        check("a_gap_miss", 32'(miss_count), 0);
        tick(2);
        check("a_dir1", 32'(direction), 32'(exp_dir[1]));
        check("a_r2_active", 32'(active), 1);
        tick(20);
        check("a_over", 32'(game_over), 1);
        check("a_hit_final", 32'(hit_count), 1);
        check("a_miss_final", 32'(miss_count), 2);
        check("a_done_active", 32'(active), 0);

        // Game B: no presses; a mid-game start must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        check("b_hit_clr", 32'(hit_count), 0);
        check("b_miss_clr", 32'(miss_count), 0);
        check("b_over_clr", 32'(game_over), 0);
        check("b_dir0", 32'(direction), 32'(exp_dir[0]));
        vga_seen = 0;
        for (int n = 1; n <= 29; n++) begin
            start = (n == 12);
            tick();
            if (vga_on) vga_seen++;
            if (n == 10) check("b_dir1", 32'(direction), 32'(exp_dir[1]));
            if (n == 20) check("b_dir2", 32'(direction), 32'(exp_dir[2]));
        end
        start = 1'b0;
        check("b_over_early", 32'(game_over), 0);
        tick();
        check("b_over", 32'(game_over), 1);
        check("b_miss", 32'(miss_count), 3);
        check("b_hit", 32'(hit_count), 0);
        check("b_vga_seen", vga_seen, 0);

        // Game C: double press, last-cycle press, reset during HIT.
        start = 1'b1; tick(); start = 1'b0;
        btn = (4'b0001 << exp_dir[0]) | (4'b0001 << (exp_dir[0] ^ 2'd1));
        tick(2); check("c_miss_pre", 32'(miss_count), 0);
        tick();
        check("c_miss_bad", 32'(miss_count), 1);
        check("c_vga_bad", 32'(vga_on), 0);
        check("c_active_bad", 32'(active), 1);
        btn = 4'b0;
        tick();
        btn = 4'b0001 << exp_dir[0];
        tick(3);
        check("c_ignore_miss", 32'(miss_count), 1);
        check("c_ignore_hit", 32'(hit_count), 0);
        check("c_ignore_vga", 32'(vga_on), 0);
        btn = 4'b0;
        tick(); check("c_gap1", 32'(active), 0);
        tick(2);
        check("c_dir1", 32'(direction), 32'(exp_dir[1]));
        tick(5);
        btn = 4'b0001 << exp_dir[1];
        tick(2);
        check("c_last_pre_hit", 32'(hit_count), 0);
        check("c_last_pre_act", 32'(active), 1);
        tick();
        check("c_last_hit", 32'(hit_count), 1);
        check("c_last_miss", 32'(miss_count), 1);
        check("c_last_gap", 32'(active), 0);
        check("c_last_vga", 32'(vga_on), 0);
        btn = 4'b0;
        tick();
        check("c_no_double", 32'(hit_count), 1);
        tick();
        check("c_r3_active", 32'(active), 1);
        check("c_dir2", 32'(direction), 32'(exp_dir[2]));
        btn = 4'b0001 << exp_dir[2];
        tick(3);
        check("c_hit_vga", 32'(vga_on), 1);
        check("c_hit2", 32'(hit_count), 2);
        reset = 1'b1;
        tick();
        check_idle("c_reset");
        reset = 1'b0; btn = 4'b0;
        tick(2);

        // Replay after reset reproduces the direction sequence.
        start = 1'b1; tick(); start = 1'b0;
        check("r_dir0", 32'(direction), 32'(exp_dir[0]));
        tick(10); check("r_dir1", 32'(direction), 32'(exp_dir[1]));
        tick(10); check("r_dir2", 32'(direction), 32'(exp_dir[2]));
        tick(10);
        check("r_over", 32'(game_over), 1);
        check("r_miss", 32'(miss_count), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
